// File: rtl/wb_dcache_flush_ctrl.sv
// wb_dcache_flush_ctrl: walks every set of the write-back data cache, writes
// back each dirty line (lowest way first) and optionally invalidates the set.
// Owns the tag arrays and the writeback unit for the duration of a flush.
//
// Optional feature: define WB_DCACHE_FLUSH_COUNT_EN to keep a count of
// written-back lines on wb_count_o; when undefined wb_count_o is tied to 0.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   flush_req_i/inval_i       start request and invalidate-after-writeback mode
//   busy_o, flush_ack_o       flush in progress, one-cycle completion pulse
//   tag_req_o/gnt_i/set_o     tag read request handshake for the scanned set
//   tag_rvalid_i/dirty_i      tag read response, per-way dirty bits
//   wb_req_o/gnt_i/set_o/way_o writeback request handshake
//   wb_done_i                 writeback of the granted line completed
//   inv_we_o/inv_set_o        one-cycle invalidate of every way of a set
//   wb_count_o                lines written back in the last/current flush
module wb_dcache_flush_ctrl #(
  parameter int unsigned DCACHE_BYTE_SIZE  = 32768,
  parameter int unsigned DCACHE_SET_ASSOC  = 8,
  parameter int unsigned DCACHE_LINE_WIDTH = 128,
  localparam int unsigned NR_SETS = DCACHE_BYTE_SIZE / (DCACHE_SET_ASSOC * DCACHE_LINE_WIDTH / 8),
  localparam int unsigned IDX_W   = $clog2(NR_SETS),
  localparam int unsigned WAY_W   = $clog2(DCACHE_SET_ASSOC),
  localparam int unsigned CNT_W   = IDX_W + WAY_W + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_req_i,
  input  logic                        flush_inval_i,
  output logic                        busy_o,
  output logic                        flush_ack_o,
  output logic                        tag_req_o,
  input  logic                        tag_gnt_i,
  output logic [IDX_W-1:0]            tag_set_o,
  input  logic                        tag_rvalid_i,
  input  logic [DCACHE_SET_ASSOC-1:0] tag_dirty_i,
  output logic                        wb_req_o,
  input  logic                        wb_gnt_i,
  output logic [IDX_W-1:0]            wb_set_o,
  output logic [WAY_W-1:0]            wb_way_o,
  input  logic                        wb_done_i,
  output logic                        inv_we_o,
  output logic [IDX_W-1:0]            inv_set_o,
  output logic [CNT_W-1:0]            wb_count_o
);

  typedef enum logic [3:0] {
    IDLE, TAG_REQ, TAG_WAIT, SCAN, WB_REQ, WB_WAIT, INV, NEXT, DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            set_q, set_d;
  logic [DCACHE_SET_ASSOC-1:0] mask_q, mask_d;
  logic [WAY_W-1:0]            way_q, way_d;
  logic                        inval_q, inval_d;
  logic [WAY_W-1:0]            low_way;

  logic busy_q, busy_d, ack_q, ack_d, tag_req_q, tag_req_d;
  logic wb_req_q, wb_req_d, inv_we_q, inv_we_d;

  // State, datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      set_q     <= '0;
      mask_q    <= '0;
      way_q     <= '0;
      inval_q   <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      tag_req_q <= 1'b0;
      wb_req_q  <= 1'b0;
      inv_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      mask_q    <= mask_d;
      way_q     <= way_d;
      inval_q   <= inval_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      tag_req_q <= tag_req_d;
      wb_req_q  <= wb_req_d;
      inv_we_q  <= inv_we_d;
    end
  end

  // Lowest-index dirty way of the latched mask
  always_comb begin
    low_way = '0;
    for (int i = DCACHE_SET_ASSOC - 1; i >= 0; i--) begin
      if (mask_q[i]) low_way = WAY_W'(i);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    mask_d  = mask_q;
    way_d   = way_q;
    inval_d = inval_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          inval_d = flush_inval_i;
          set_d   = '0;
          state_d = TAG_REQ;
        end
      end
      TAG_REQ:  if (tag_gnt_i) state_d = TAG_WAIT;
      TAG_WAIT: begin
        if (tag_rvalid_i) begin
          mask_d  = tag_dirty_i;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (|mask_q) begin
          way_d   = low_way;
          state_d = WB_REQ;
        end else begin
          state_d = inval_q ? INV : NEXT;
        end
      end
      WB_REQ:   if (wb_gnt_i) state_d = WB_WAIT;
      WB_WAIT: begin
        if (wb_done_i) begin
          mask_d[way_q] = 1'b0;
          state_d       = SCAN;
        end
      end
      INV:      state_d = NEXT;
      NEXT: begin
        if (set_q == IDX_W'(NR_SETS - 1)) begin
          state_d = DONE;
        end else begin
          set_d   = set_q + IDX_W'(1);
          state_d = TAG_REQ;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the strobes come straight from flops
  always_comb begin
    busy_d    = (state_d != IDLE);
    ack_d     = (state_d == DONE);
    tag_req_d = (state_d == TAG_REQ);
    wb_req_d  = (state_d == WB_REQ);
    inv_we_d  = (state_d == INV);
  end

  assign busy_o      = busy_q;
  assign flush_ack_o = ack_q;
  assign tag_req_o   = tag_req_q;
  assign wb_req_o    = wb_req_q;
  assign inv_we_o    = inv_we_q;
  assign tag_set_o   = set_q;
  assign wb_set_o    = set_q;
  assign inv_set_o   = set_q;
  assign wb_way_o    = way_q;

`ifdef WB_DCACHE_FLUSH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Written-back line counter, cleared at flush start, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && flush_req_i) begin
      cnt_d = '0;
    end else if (state_q == WB_WAIT && wb_done_i && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign wb_count_o = cnt_q;
`else
  assign wb_count_o = '0;
`endif

endmodule

// File: doc/wb_dcache_flush_ctrl.md
Name: wb_dcache_flush_ctrl

Overview:
Sequencer that walks every set of the write-back data cache and writes back all dirty lines. It can optionally invalidate each set after its dirty lines are written back. It sits between the fence/flush request source and the dcache tag/data arrays and miss/writeback unit, and owns those resources while a flush runs. Geometry comes from the core's cache configuration (32 KiB, 8-way, 128-bit lines).

Parameters:
- DCACHE_BYTE_SIZE, 32768, total data cache capacity in bytes.
- DCACHE_SET_ASSOC, 8, number of ways (NrWays).
- DCACHE_LINE_WIDTH, 128, line width in bits.
- Derived NR_SETS = DCACHE_BYTE_SIZE / (DCACHE_SET_ASSOC * DCACHE_LINE_WIDTH/8) = 256.
- Derived IDX_W = clog2(NR_SETS) = 8; WAY_W = clog2(NrWays) = 3; CNT_W = IDX_W + WAY_W + 1 = 12.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- flush_req_i  in  1  start flush; sampled only in IDLE.
- flush_inval_i  in  1  invalidate each set after writeback; captured at start.
- busy_o  out  1  high in every state except IDLE.
- flush_ack_o  out  1  one-cycle pulse on completion.
- tag_req_o  out  1  tag-array read request.
- tag_gnt_i  in  1  tag read grant.
- tag_set_o  out  IDX_W  set index being scanned.
- tag_rvalid_i  in  1  tag read data valid.
- tag_dirty_i  in  NrWays  per-way dirty bits (valid AND dirty); used only when tag_rvalid_i is high.
- wb_req_o  out  1  line writeback request.
- wb_gnt_i  in  1  writeback accepted.
- wb_set_o  out  IDX_W  set of the line to write back.
- wb_way_o  out  WAY_W  way of the line to write back.
- wb_done_i  in  1  writeback completed (data written to memory).
- inv_we_o  out  1  one-cycle pulse: clear valid and dirty for all ways of inv_set_o.
- inv_set_o  out  IDX_W  set to invalidate.
- wb_count_o  out  CNT_W  number of lines written back in the last/current flush.

Behaviour:
- Reset: state IDLE; set counter 0; dirty mask 0.
- Reset values: all outputs 0, including tag_set_o, wb_set_o, wb_way_o, inv_set_o and wb_count_o.
- Reset asserted mid-flush aborts immediately with no ack; any in-flight wb_done_i is ignored.
- States: IDLE, TAG_REQ, TAG_WAIT, SCAN, WB_REQ, WB_WAIT, INV, NEXT, DONE.
- IDLE:
  - on flush_req_i: capture flush_inval_i, clear set counter and wb_count_o, go to TAG_REQ.
  - flush_req_i in any other state is ignored.
- TAG_REQ: tag_req_o=1, tag_set_o=set.
  - Hold the request with tag_set_o stable until tag_gnt_i, then go to TAG_WAIT.
- TAG_WAIT: wait any number of cycles (≥1) for tag_rvalid_i, then latch tag_dirty_i into the dirty mask and go to SCAN.
  - tag_rvalid_i in the grant cycle itself is ignored.
- SCAN:
  - mask nonzero: select the lowest-index dirty way, go to WB_REQ.
  - mask zero: go to INV if inval was captured, else NEXT.
- WB_REQ: wb_req_o=1, wb_set_o/wb_way_o stable until wb_gnt_i, then go to WB_WAIT.
- WB_WAIT: on wb_done_i, clear that way's mask bit, increment wb_count_o, go to SCAN.
  - wb_done_i in any other state is ignored.
  - wb_done_i cannot coincide with wb_gnt_i.
- INV: inv_we_o=1 for exactly one cycle with inv_set_o=set, then go to NEXT.
- NEXT:
  - set == NR_SETS-1: go to DONE; no wrap, no extra tag read.
  - otherwise: set+1, go to TAG_REQ.
- DONE: flush_ack_o=1 for one cycle, go to IDLE.
  - A flush_req_i seen in the following IDLE cycle starts a new flush.
- Timing with immediate grant and minimum tag latency: 4 cycles per clean set (TAG_REQ, TAG_WAIT, SCAN, NEXT).
- Each dirty line adds at least 3 cycles (SCAN, WB_REQ, WB_WAIT).
- wb_count_o saturates at 2^CNT_W-1; NR_SETS*NrWays = 2048 always fits, so saturation is never reached.

Optional Feature:
- Macro WB_DCACHE_FLUSH_COUNT_EN.
- Defined: wb_count_o behaves as described.
- Undefined: the counter logic is removed and wb_count_o is tied to 0; all other behaviour is unchanged.

Test Plan:
- All sets clean, inval=0, grants immediate, tag_rvalid_i in the cycle after the grant, req in cycle 0:
  - 256 tag reads with sets 0..255 in order, no wb_req_o, no inv_we_o.
  - flush_ack_o is a single pulse in cycle 1025; wb_count_o=0.
- Set 3 dirty mask 8'b0010_0001, inval=1, all other sets clean:
  - writebacks in order (set3, way0) then (set3, way5), then one inv_we_o with inv_set_o=3 after the second wb_done_i.
  - inv_we_o pulses for all 256 sets; wb_count_o=2 (0 without the macro).
- tag_gnt_i held low for 3 cycles on set 10:
  - tag_req_o stays high for 4 cycles with tag_set_o=10 stable.
  - wb_gnt_i held low for 5 cycles: wb_req_o, wb_set_o and wb_way_o stay stable throughout.
- wb_done_i pulsed while in TAG_WAIT, and flush_req_i pulsed mid-flush: no state change, no count change, no second flush after ack.
- rst_i asserted while in WB_WAIT on set 100:
  - all outputs 0 in the cycle after the asserting edge, no flush_ack_o.
  - a subsequent flush restarts at set 0.
- All 2048 lines dirty, inval=0, macro on: 2048 writebacks in set-major, way-ascending order; wb_count_o=2048 at ack.
